// File: rtl/nmr_scan_sequencer.sv
// nmr_scan_sequencer
// Multi-scan NMR pulse sequencer. Repeats PULSE / DEAD / ACQ / FLUSH / WAIT_TR
// scans at a fixed repetition time so the acquired echoes can be averaged.
// Timing configuration is snapshotted at start so register writes made during
// a run cannot disturb the scan in progress.

module nmr_scan_sequencer #(
  parameter int CNT_W  = 32,
  parameter int SCAN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SCAN_W-1:0] cfg_nb_scans,
  input  logic [CNT_W-1:0]  cfg_pulse_len,
  input  logic [CNT_W-1:0]  cfg_dead_time,
  input  logic [CNT_W-1:0]  cfg_acq_len,
  input  logic [CNT_W-1:0]  cfg_rep_time,
  input  logic              wr_done,
  output logic              en_gen,
  output logic              rst_writer_n,
  output logic              acq_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic [SCAN_W-1:0] scan_idx,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PULSE   = 3'd2,
    S_DEAD    = 3'd3,
    S_ACQ     = 3'd4,
    S_FLUSH   = 3'd5,
    S_WAIT_TR = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic start_q;
  logic start_edge;
  logic cfg_bad;

  logic [SCAN_W-1:0] nb_sh;
  logic [CNT_W-1:0]  p_sh;
  logic [CNT_W-1:0]  d_sh;
  logic [CNT_W-1:0]  a_sh;
  logic [CNT_W-1:0]  tr_sh;

  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] scan_tmr;

  logic pulse_end;
  logic dead_end;
  logic acq_end;
  logic tr_reached;
  logic last_scan;

  logic done_nxt;
  logic aborted_nxt;
  logic cfg_err_nxt;

  assign start_edge = start & ~start_q;
  assign cfg_bad    = (cfg_nb_scans == '0) | (cfg_pulse_len == '0) | (cfg_acq_len == '0);

  // Phase ends are compared against the snapshot so live cfg writes are ignored.
  assign pulse_end  = (phase_cnt == p_sh - CNT_W'(1));
  assign dead_end   = (phase_cnt == d_sh - CNT_W'(1));
  assign acq_end    = (phase_cnt == a_sh - CNT_W'(1));
  assign last_scan  = (scan_idx == nb_sh - SCAN_W'(1));

  // One extra bit keeps timer+1 from wrapping when the timer is saturated.
  assign tr_reached = ({1'b0, scan_tmr} + (CNT_W+1)'(1)) >= {1'b0, tr_sh};

  assign state_o = state;

  // Next-state selection; abort overrides every other transition outside IDLE.
  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    cfg_err_nxt = 1'b0;
    if ((state != S_IDLE) && abort) begin
      state_nxt   = S_IDLE;
      aborted_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            if (cfg_bad) begin
              cfg_err_nxt = 1'b1;
            end else begin
              state_nxt = S_ARM;
            end
          end
        end
        S_ARM: begin
          state_nxt = S_PULSE;
        end
        S_PULSE: begin
          if (pulse_end) begin
            state_nxt = (d_sh == '0) ? S_ACQ : S_DEAD;
          end
        end
        S_DEAD: begin
          if (dead_end) begin
            state_nxt = S_ACQ;
          end
        end
        S_ACQ: begin
          if (acq_end) begin
            state_nxt = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (wr_done) begin
            state_nxt = S_WAIT_TR;
          end
        end
        S_WAIT_TR: begin
          if (tr_reached) begin
            if (last_scan) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_PULSE;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Start edge detector; it keeps tracking start during reset so a level held
  // high across reset is not mistaken for a fresh request.
  always_ff @(posedge clk) begin
    start_q <= start;
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      en_gen       <= 1'b0;
      acq_en       <= 1'b0;
      rst_writer_n <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      en_gen       <= (state_nxt == S_PULSE);
      acq_en       <= (state_nxt == S_ACQ);
      rst_writer_n <= (state_nxt != S_ARM);
      busy         <= (state_nxt != S_IDLE);
      done         <= done_nxt;
      aborted      <= aborted_nxt;
      cfg_err      <= cfg_err_nxt;
    end
  end

  // Snapshot of the timing configuration, taken only when a run is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nb_sh <= '0;
      p_sh  <= '0;
      d_sh  <= '0;
      a_sh  <= '0;
      tr_sh <= '0;
    end else if ((state == S_IDLE) && (state_nxt == S_ARM)) begin
      nb_sh <= cfg_nb_scans;
      p_sh  <= cfg_pulse_len;
      d_sh  <= cfg_dead_time;
      a_sh  <= cfg_acq_len;
      tr_sh <= cfg_rep_time;
    end
  end

  // Per-state cycle counter, restarted on every state change and parked in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if ((state_nxt != state) || (state_nxt == S_IDLE)) begin
      phase_cnt <= '0;
    end else if (phase_cnt != '1) begin
      phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

  // Scan timer: zero on the first PULSE cycle, then saturating count to TR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_tmr <= '0;
    end else if ((state_nxt == S_PULSE) && (state != S_PULSE)) begin
      scan_tmr <= '0;
    end else if (scan_tmr != '1) begin
      scan_tmr <= scan_tmr + CNT_W'(1);
    end
  end

  // Scan index: cleared on ARM, advanced on each WAIT_TR to PULSE loop-back,
  // and left untouched on abort so software can see where the run stopped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx <= '0;
    end else if (state_nxt == S_ARM) begin
      scan_idx <= '0;
    end else if ((state == S_WAIT_TR) && (state_nxt == S_PULSE)) begin
      scan_idx <= scan_idx + SCAN_W'(1);
    end
  end

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// tb_nmr_scan_sequencer
// Each accepted run pushes one expected record per scan; a monitor rebuilds
// the observed scan from en_gen/acq_en edges and pops/compares on acq_en fall.

module tb_nmr_scan_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_nb_scans;
  logic [31:0] cfg_pulse_len;
  logic [31:0] cfg_dead_time;
  logic [31:0] cfg_acq_len;
  logic [31:0] cfg_rep_time;
  logic        wr_done;
  logic        en_gen;
  logic        rst_writer_n;
  logic        acq_en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;
  logic [15:0] scan_idx;
  logic [2:0]  state_o;

  typedef struct {
    int pulse_off;
    int pulse_len;
    int acq_delay;
    int acq_len;
    int idx;
  } scan_rec_t;

  scan_rec_t expQ[$];

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;
  int t0         = 0;
  int doneCnt    = 0;
  int abortCnt   = 0;
  int errCnt     = 0;

  int pulseRise = 0;
  int pulseLen  = 0;
  int pulseIdx  = 0;
  int acqRise   = 0;
  logic prevEn   = 1'b0;
  logic prevAcq  = 1'b0;
  logic prevBusy = 1'b0;

  nmr_scan_sequencer #(.CNT_W(32), .SCAN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_nb_scans (cfg_nb_scans),
    .cfg_pulse_len(cfg_pulse_len),
    .cfg_dead_time(cfg_dead_time),
    .cfg_acq_len  (cfg_acq_len),
    .cfg_rep_time (cfg_rep_time),
    .wr_done      (wr_done),
    .en_gen       (en_gen),
    .rst_writer_n (rst_writer_n),
    .acq_en       (acq_en),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .cfg_err      (cfg_err),
    .scan_idx     (scan_idx),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Loads cfg, pushes the expected scans (0..lastScan, last one with lastAcq
  // acquisition cycles) and raises start; returns one negedge after the edge.
  task automatic applyStimulus(input int n, input int p, input int d, input int a,
                               input int tr, input int lastScan, input int lastAcq);
    scan_rec_t r;
    int period;
    period = (tr > p + d + a + 2) ? tr : p + d + a + 2;
    for (int i = 0; i <= lastScan; i++) begin
      r.pulse_off = 1 + i * period;
      r.pulse_len = p;
      r.acq_delay = p + d;
      r.acq_len   = (i == lastScan) ? lastAcq : a;
      r.idx       = i;
      expQ.push_back(r);
    end
    cfg_nb_scans  = 16'(n);
    cfg_pulse_len = 32'(p);
    cfg_dead_time = 32'(d);
    cfg_acq_len   = 32'(a);
    cfg_rep_time  = 32'(tr);
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) checkOutput(tag, 1, 0);
    @(negedge clk);
  endtask

  task automatic dropStart();
    start = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: reconstructs each scan from output edges and scores it.
  always @(negedge clk) begin
    scan_rec_t e;
    if (!rst_n) begin
      prevEn   = 1'b0;
      prevAcq  = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (busy && !prevBusy) t0 = cyc;
      if (en_gen && !prevEn) begin
        pulseRise = cyc;
        pulseIdx  = int'(scan_idx);
      end
      if (!en_gen && prevEn) pulseLen = cyc - pulseRise;
      if (acq_en && !prevAcq) acqRise = cyc;
      if (!acq_en && prevAcq) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_scan", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulse_offset", pulseRise - t0, e.pulse_off);
          checkOutput("pulse_len", pulseLen, e.pulse_len);
          checkOutput("acq_delay", acqRise - pulseRise, e.acq_delay);
          checkOutput("acq_len", cyc - acqRise, e.acq_len);
          checkOutput("scan_idx", pulseIdx, e.idx);
        end
      end
      if (done) doneCnt++;
      if (aborted) abortCnt++;
      if (cfg_err) errCnt++;
      prevEn   = en_gen;
      prevAcq  = acq_en;
      prevBusy = busy;
    end
  end

  initial begin
    int k;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    wr_done       = 1'b1;
    cfg_nb_scans  = '0;
    cfg_pulse_len = '0;
    cfg_dead_time = '0;
    cfg_acq_len   = '0;
    cfg_rep_time  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_writer_n", rst_writer_n, 1);
    checkOutput("rst_en_gen", en_gen, 0);
    checkOutput("rst_scan_idx", scan_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] three scans, D=2, TR=40");
    applyStimulus(3, 4, 2, 8, 40, 2, 8);
    checkOutput("arm_state", state_o, 1);
    checkOutput("arm_busy", busy, 1);
    checkOutput("arm_writer_n", rst_writer_n, 0);
    @(negedge clk);
    checkOutput("pulse_state", state_o, 2);
    checkOutput("pulse_en_gen", en_gen, 1);
    checkOutput("pulse_writer_n", rst_writer_n, 1);
    waitIdle("timeout_run1", 500);
    checkOutput("run1_done_cnt", doneCnt, 1);
    checkOutput("run1_busy", busy, 0);
    checkOutput("run1_queue", expQ.size(), 0);
    dropStart();

    $display("[TB] two scans, D=0, TR shorter than scan");
    applyStimulus(2, 4, 0, 8, 5, 1, 8);
    waitIdle("timeout_run2", 300);
    checkOutput("run2_done_cnt", doneCnt, 2);
    checkOutput("run2_queue", expQ.size(), 0);
    dropStart();

    $display("[TB] single scan with stalled writer");
    wr_done = 1'b0;
    applyStimulus(1, 4, 2, 8, 10, 0, 8);
    k = 0;
    while (state_o != 3'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("flush_reached", state_o, 5);
    k = 1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (state_o == 3'd5) k++;
    end
    checkOutput("flush_cycles", k, 20);
    wr_done = 1'b1;
    @(negedge clk);
    checkOutput("flush_exit_state", state_o, 6);
    waitIdle("timeout_run3", 100);
    checkOutput("run3_done_cnt", doneCnt, 3);
    dropStart();

    $display("[TB] abort in third ACQ cycle of scan 1");
    applyStimulus(3, 4, 2, 8, 40, 1, 3);
    k = 0;
    while (!(acq_en && scan_idx == 16'd1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("abort_acq_seen", int'(acq_en), 1);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_state", state_o, 0);
    checkOutput("abort_acq_en", acq_en, 0);
    checkOutput("abort_pulse", aborted, 1);
    checkOutput("abort_scan_idx", scan_idx, 1);
    checkOutput("abort_busy", busy, 0);
    @(negedge clk);
    checkOutput("abort_pulse_width", aborted, 0);
    checkOutput("abort_done_cnt", doneCnt, 3);
    checkOutput("abort_cnt", abortCnt, 1);
    checkOutput("abort_queue", expQ.size(), 0);
    dropStart();

    $display("[TB] rejected starts");
    applyStimulus(2, 0, 2, 8, 40, -1, 0);
    checkOutput("err_p0_pulse", cfg_err, 1);
    checkOutput("err_p0_busy", busy, 0);
    @(negedge clk);
    checkOutput("err_p0_width", cfg_err, 0);
    checkOutput("err_p0_writer_n", rst_writer_n, 1);
    dropStart();
    applyStimulus(0, 4, 2, 8, 40, -1, 0);
    checkOutput("err_n0_pulse", cfg_err, 1);
    checkOutput("err_n0_busy", busy, 0);
    @(negedge clk);
    checkOutput("err_cnt", errCnt, 2);
    dropStart();

    $display("[TB] reset mid-PULSE with start held high");
    applyStimulus(3, 4, 2, 8, 40, -1, 0);
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_en_gen", en_gen, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_en_gen", en_gen, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_state", state_o, 0);
    checkOutput("mid_rst_writer_n", rst_writer_n, 1);
    checkOutput("mid_rst_scan_idx", scan_idx, 0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) k++;
    end
    checkOutput("no_restart_busy", k, 0);
    checkOutput("final_done_cnt", doneCnt, 3);
    checkOutput("final_queue", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
